aes_core_scheduler: RTL and testbench

// Shares one AES core (128-bit block, 128-bit key, start/done) among NREQ requesters.

---
 rtl/aes_core_scheduler.sv | 179 +++++++++++++++++
 tb/tb_aes_core_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler: shares one AES core among NREQ requesters.
// Round-robin picks a pending request, latches its block/key, pulses core_start,
// then waits for core_done (or a timeout) and returns the tagged result.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. req_ready is combinational and one-hot, only in IDLE; resp_valid is
// registered and resp_* stay stable until resp_ready is seen.
module aes_core_scheduler #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*128-1:0]    req_block,
  input  logic [NREQ*128-1:0]    req_key,
  output logic                   core_start,
  output logic [127:0]           core_block,
  output logic [127:0]           core_key,
  input  logic                   core_done,
  input  logic [127:0]           core_result,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [127:0]           resp_block,
  output logic                   resp_err,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             core_start_q, core_start_d;
  logic [127:0]     core_block_q, core_block_d;
  logic [127:0]     core_key_q, core_key_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [127:0]     resp_block_q, resp_block_d;
  logic             resp_err_q, resp_err_d;
  logic             busy_q, busy_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             accept;
  logic             timeout_hit;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping mod NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot accept towards the requesters, offered only while idle.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found && !reset) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept      = |(req_ready & req_valid);
  assign timeout_hit = (cnt_q == CNTW'(TIMEOUT - 1));

  // State register and all datapath flops; reset abandons any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      core_block_q <= '0;
      core_key_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_block_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      core_block_q <= core_block_d;
      core_key_q   <= core_key_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_block_q <= resp_block_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (core_done || timeout_hit) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered-output next values; core_done beats a coincident timeout.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
    core_block_d = core_block_q;
    core_key_d   = core_key_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_block_d = resp_block_q;
    resp_err_d   = resp_err_q;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          core_block_d = req_block[int'(grant_idx)*128 +: 128];
          core_key_d   = req_key[int'(grant_idx)*128 +: 128];
          resp_id_d    = grant_idx;
          core_start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNTW'(1);
        if (core_done) begin
          resp_block_d = core_result;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          resp_block_d = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = (resp_id_q == IDW'(NREQ - 1)) ? '0 : resp_id_q + IDW'(1);
        end
      end
      default: ;
    endcase
  end

  assign core_start = core_start_q;
  assign core_block = core_block_q;
  assign core_key   = core_key_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_block = resp_block_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_core_scheduler.sv
// tb_aes_core_scheduler: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model built from timestamps of accept/done/timeout.
module tb_aes_core_scheduler;

  localparam int NREQ    = 2;
  localparam int IDW     = 1;
  localparam int TIMEOUT = 64;
  localparam int CNTW    = 7;

  localparam logic [127:0] T1_BLK = 128'h10101010202020203030303040404040;
  localparam logic [127:0] T1_KEY = 128'h11111111222222223333333344444444;
  localparam logic [127:0] T1_RES = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B0     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B1     = 128'hf0e0d0c0b0a090807060504030201000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_block = '0;
  logic [NREQ*128-1:0] req_key = '0;
  logic                core_start;
  logic [127:0]        core_block, core_key;
  logic                core_done = 1'b0;
  logic [127:0]        core_result = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [IDW-1:0]      resp_id;
  logic [127:0]        resp_block;
  logic                resp_err;
  logic                busy;

  aes_core_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_block(req_block), .req_key(req_key),
    .core_start(core_start), .core_block(core_block), .core_key(core_key),
    .core_done(core_done), .core_result(core_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_block(resp_block), .resp_err(resp_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- reference model ----------------
  int           cyc = 0;
  bit           m_init = 0, m_active = 0, m_known = 0, m_err = 0;
  int           m_ptr = 0, m_id = 0, m_start = 0, m_resp_cyc = 0;
  logic [127:0] m_block = '0, m_key = '0, m_rblk = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1; m_active = 0; m_known = 0; m_err = 0;
      m_ptr = 0; m_id = 0; m_start = 0; m_resp_cyc = 0;
      m_block = '0; m_key = '0; m_rblk = '0;
    end else if (m_init) begin
      if (!m_active) begin
        int g;
        g = rr_pick(req_valid, m_ptr);
        if (g >= 0) begin
          m_active = 1; m_known = 0; m_id = g;
          m_block = req_block[128*g +: 128];
          m_key   = req_key[128*g +: 128];
          m_start = cyc + 1;
        end
      end else if (!m_known) begin
        if (cyc > m_start && cyc <= m_start + TIMEOUT && core_done === 1'b1) begin
          m_known = 1; m_resp_cyc = cyc + 1; m_rblk = core_result; m_err = 0;
        end else if (cyc == m_start + TIMEOUT) begin
          m_known = 1; m_resp_cyc = cyc + 1; m_rblk = '0; m_err = 1;
        end
      end else if (cyc >= m_resp_cyc && resp_ready === 1'b1) begin
        m_active = 0;
        m_ptr = (m_id + 1) % NREQ;
      end
    end
    cyc++;
  end

  // ---------------- scoreboard compare + observations ----------------
  int           obs_grants[$];
  logic [127:0] obs_blocks[$];
  int           hs_cnt = 0;

  always @(negedge clk) begin
    if (!reset && m_init) begin
      logic [NREQ-1:0] exp_rr;
      bit exp_rv;
      int g;
      exp_rr = '0;
      if (!m_active) begin
        g = rr_pick(req_valid, m_ptr);
        if (g >= 0) exp_rr[g] = 1'b1;
      end
      exp_rv = m_active && m_known && (cyc >= m_resp_cyc);
      chk("req_ready", req_ready, exp_rr);
      chk("core_start", core_start, m_active && (cyc == m_start));
      chk("busy", busy, m_active);
      chk("resp_valid", resp_valid, exp_rv);
      chk("core_block", core_block, m_block);
      chk("core_key", core_key, m_key);
      chk("resp_id", resp_id, m_id);
      if (exp_rv) begin
        chk("resp_block", resp_block, m_rblk);
        chk("resp_err", resp_err, m_err);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i]) obs_grants.push_back(i);
      end
      if (core_start === 1'b1) obs_blocks.push_back(core_block);
      if (resp_valid === 1'b1 && resp_ready === 1'b1) hs_cnt++;
    end
  end

  // ---------------- driver tasks (incl. core emulator) ----------------
  int           emu_cd = 0;
  int           emu_lat = 10;
  bit           emu_rand = 0;
  logic [127:0] emu_result = '0;
  int           start_cnt = 0;

  task automatic tick();
    @(posedge clk); #1;
    core_done = 1'b0;
    if (emu_cd > 0) begin
      emu_cd--;
      if (emu_cd == 0) core_done = 1'b1;
    end else if (emu_rand && $urandom_range(0, 40) == 0) begin
      core_done = 1'b1;
      core_result = rand128();
    end
    if (core_start === 1'b1) begin
      start_cnt++;
      if (emu_rand) begin
        case ($urandom_range(0, 9))
          0: emu_lat = TIMEOUT;
          1: emu_lat = TIMEOUT + 20;
          default: emu_lat = $urandom_range(1, 12);
        endcase
        core_result = rand128();
      end else begin
        core_result = emu_result;
      end
      emu_cd = emu_lat;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; core_done = 1'b0; resp_ready = 1'b0; emu_cd = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_start(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (core_start === 1'b1) begin n = i; break; end
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL wait_start act=no_start exp=start_within_%0d", max);
    end
  endtask

  task automatic wait_resp(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (resp_valid === 1'b1) begin n = i; break; end
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL wait_resp act=no_resp exp=resp_within_%0d", max);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, s0, base, cnt;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};

    do_reset();
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_core_block", core_block, 128'h0);
    chk("rst_resp_block", resp_block, 128'h0);
    chk("rst_resp_err", resp_err, 1'b0);

    // 1: single request, done 10 cycles after start
    req_block = {128'h0, T1_BLK};
    req_key   = {128'h0, T1_KEY};
    emu_lat = 10; emu_result = T1_RES; resp_ready = 1'b1;
    s0 = start_cnt;
    req_valid = 2'b01;
    wait_start(10, n);
    req_valid = 2'b00;
    chk("t1_core_block", core_block, T1_BLK);
    chk("t1_core_key", core_key, T1_KEY);
    wait_resp(100, n);
    chk("t1_latency", n, 11);
    chk("t1_resp_id", resp_id, 1'b0);
    chk("t1_resp_block", resp_block, T1_RES);
    chk("t1_resp_err", resp_err, 1'b0);
    repeat (3) tick();
    chk("t1_one_start", start_cnt - s0, 1);

    // 2: fairness with both requesters held valid
    do_reset();
    req_block = {B1, B0};
    req_key   = {B0, B1};
    emu_lat = 3; emu_result = rand128(); resp_ready = 1'b1;
    obs_grants.delete(); obs_blocks.delete();
    base = hs_cnt;
    req_valid = 2'b11;
    for (int i = 0; i < 200 && obs_grants.size() < 4; i++) tick();
    req_valid = 2'b00;
    for (int i = 0; i < 60 && hs_cnt - base < 4; i++) tick();
    chk("t2_jobs", hs_cnt - base, 4);
    chk("t2_grants", obs_grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_grants.size()) chk("t2_order", obs_grants[i], exp_order[i]);
      if (i < obs_blocks.size()) chk("t2_block", obs_blocks[i], (exp_order[i] == 0) ? B0 : B1);
    end

    // 3: timeout, then a normal job
    tick();
    emu_lat = 1000; resp_ready = 1'b1;
    req_valid = 2'b01;
    wait_start(10, n);
    req_valid = 2'b00;
    wait_resp(200, n);
    chk("t3_timeout_latency", n, TIMEOUT + 1);
    chk("t3_err", resp_err, 1'b1);
    chk("t3_block", resp_block, 128'h0);
    tick();
    emu_lat = 5; emu_result = 128'h0badf00d_0badf00d_cafe0001_cafe0002;
    req_valid = 2'b10;
    wait_start(10, n);
    req_valid = 2'b00;
    wait_resp(100, n);
    chk("t3_next_latency", n, 6);
    chk("t3_next_err", resp_err, 1'b0);
    chk("t3_next_id", resp_id, 1'b1);
    chk("t3_next_block", resp_block, 128'h0badf00d_0badf00d_cafe0001_cafe0002);

    // 4: response back-pressure
    tick();
    resp_ready = 1'b0; emu_lat = 3; emu_result = 128'h44444444_33333333_22222222_11111111;
    req_valid = 2'b01;
    wait_start(10, n);
    req_valid = 2'b11;
    wait_resp(100, n);
    chk("t4_latency", n, 4);
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", resp_valid, 1'b1);
      chk("t4_hold_ready", req_ready, 2'b00);
      chk("t4_hold_block", resp_block, 128'h44444444_33333333_22222222_11111111);
      chk("t4_hold_id", resp_id, 1'b0);
    end
    chk("t4_no_start", start_cnt - s0, 0);
    resp_ready = 1'b1;
    tick();
    chk("t4_idle_busy", busy, 1'b0);
    chk("t4_idle_valid", resp_valid, 1'b0);
    chk("t4_idle_ready", req_ready, 2'b10);
    req_valid = 2'b00;

    // 5: done on the timeout cycle wins; spurious done in IDLE is ignored
    tick();
    emu_lat = TIMEOUT; emu_result = 128'h55aa55aa_00ff00ff_12345678_9abcdef0;
    req_valid = 2'b01;
    wait_start(10, n);
    req_valid = 2'b00;
    wait_resp(200, n);
    chk("t5_latency", n, TIMEOUT + 1);
    chk("t5_err", resp_err, 1'b0);
    chk("t5_block", resp_block, 128'h55aa55aa_00ff00ff_12345678_9abcdef0);
    repeat (3) tick();
    core_done = 1'b1; core_result = rand128();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid === 1'b1 || busy === 1'b1) cnt++;
    end
    chk("t5_spurious", cnt, 0);

    // 6: asynchronous reset while waiting on the core
    emu_lat = 1000;
    req_valid = 2'b10;
    wait_start(10, n);
    req_valid = 2'b00;
    repeat (3) tick();
    #3 reset = 1'b1;
    #1;
    chk("t6_core_start", core_start, 1'b0);
    chk("t6_core_block", core_block, 128'h0);
    chk("t6_core_key", core_key, 128'h0);
    chk("t6_resp_valid", resp_valid, 1'b0);
    chk("t6_resp_id", resp_id, 1'b0);
    chk("t6_resp_block", resp_block, 128'h0);
    chk("t6_resp_err", resp_err, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_req_ready", req_ready, 2'b00);
    emu_cd = 0;
    repeat (2) tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid === 1'b1) cnt++;
    end
    chk("t6_no_resp", cnt, 0);
    req_valid = 2'b11;
    #1;
    chk("t6_ptr_reset", req_ready, 2'b01);
    emu_lat = 2; emu_result = rand128();
    tick();
    req_valid = 2'b00;
    wait_resp(50, n);
    chk("t6_after_id", resp_id, 1'b0);

    // randomized traffic
    emu_rand = 1;
    base = hs_cnt;
    for (int i = 0; i < 2500; i++) begin
      tick();
      req_valid = NREQ'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 3) != 0);
      req_block = {rand128(), rand128()};
      req_key = {rand128(), rand128()};
    end
    chk("rand_jobs_seen", (hs_cnt - base) > 20, 1'b1);
    req_valid = '0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
